// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// sram_pkg : shared sizing defaults and master ids for the SRAM arbiter
// Rev 1.0
// ============================================================================
package sram_pkg;

   localparam int N_DEF = 4;
   localparam int W_DEF = 4;
   localparam int ID_W  = 1;

   typedef logic [ID_W-1:0] id_t;

   localparam id_t M0 = 1'b0;
   localparam id_t M1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// rr_pick2 : combinational 2-way round-robin picker
// Rev 1.0
// ============================================================================
module rr_pick2
   import sram_pkg::*;
(
   input  logic [1:0] i_req,
   input  id_t        i_last,
   output logic [1:0] o_gnt,
   output id_t        o_id
);

   // Under contention the master that was not served last wins.
   assign o_gnt[0] = i_req[0] & (~i_req[1] | (i_last == M1));
   assign o_gnt[1] = i_req[1] & (~i_req[0] | (i_last == M0));
   assign o_id     = o_gnt[1] ? M1 : M0;

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// sram_arbiter : two-master round-robin access to one single-port SRAM
// Rev 1.0
// ============================================================================
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF,
   parameter int A = $clog2(N)
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0,
   input  logic         req1,
   input  logic         we0,
   input  logic         we1,
   input  logic [A-1:0] addr0,
   input  logic [A-1:0] addr1,
   input  logic [W-1:0] wdata0,
   input  logic [W-1:0] wdata1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         rvalid0,
   output logic         rvalid1,
   output logic [W-1:0] rdata,
   output logic         sram_cs,
   output logic         sram_wr_en,
   output logic [A-1:0] sram_addr,
   output logic [W-1:0] sram_wr_data,
   input  logic [W-1:0] sram_rd_data
);

   id_t        r_last;
   logic       r_rd_pend;
   id_t        r_rd_id;

   logic [1:0] w_pick_gnt;
   id_t        w_pick_id;
   logic [1:0] w_gnt;
   logic       w_any;

   rr_pick2 u_pick (
      .i_req  ({req1, req0}),
      .i_last (r_last),
      .o_gnt  (w_pick_gnt),
      .o_id   (w_pick_id)
   );

   // Grants are suppressed while reset is held so no access reaches the SRAM.
   assign w_gnt = rst_n ? w_pick_gnt : 2'b00;
   assign w_any = |w_gnt;
   assign gnt0  = w_gnt[0];
   assign gnt1  = w_gnt[1];

   always_comb begin
      sram_cs      = w_any;
      sram_wr_en   = 1'b0;
      sram_addr    = '0;
      sram_wr_data = '0;
      if (w_gnt[1]) begin
         sram_wr_en   = we1;
         sram_addr    = addr1;
         sram_wr_data = wdata1;
      end else if (w_gnt[0]) begin
         sram_wr_en   = we0;
         sram_addr    = addr0;
         sram_wr_data = wdata0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last    <= M1;
         r_rd_pend <= 1'b0;
         r_rd_id   <= M0;
      end else begin
         if (w_any) begin
            r_last <= w_pick_id;
         end
         r_rd_pend <= w_any & ~sram_wr_en;
         if (w_any && !sram_wr_en) begin
            r_rd_id <= w_pick_id;
         end
      end
   end

   assign rvalid0 = r_rd_pend & (r_rd_id == M0);
   assign rvalid1 = r_rd_pend & (r_rd_id == M1);
   assign rdata   = sram_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sram_arbiter : scoreboard bench for sram_arbiter with a behavioural SRAM
// Rev 1.0
// ============================================================================
module tb_sram_arbiter;

   localparam int N = 4;
   localparam int W = 4;
   localparam int A = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0, req1, we0, we1;
   logic [A-1:0] addr0, addr1;
   logic [W-1:0] wdata0, wdata1;
   logic         gnt0, gnt1, rvalid0, rvalid1;
   logic [W-1:0] rdata;
   logic         sram_cs, sram_wr_en;
   logic [A-1:0] sram_addr;
   logic [W-1:0] sram_wr_data;
   logic [W-1:0] sram_rd_data;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic         id;
      logic [W-1:0] data;
   } exp_t;

   exp_t         q[$];
   logic [W-1:0] ref_mem [N];
   logic [W-1:0] sram_mem [N];

   always #5 clk = ~clk;

   sram_arbiter #(.N(N), .W(W), .A(A)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0         (req0),
      .req1         (req1),
      .we0          (we0),
      .we1          (we1),
      .addr0        (addr0),
      .addr1        (addr1),
      .wdata0       (wdata0),
      .wdata1       (wdata1),
      .gnt0         (gnt0),
      .gnt1         (gnt1),
      .rvalid0      (rvalid0),
      .rvalid1      (rvalid1),
      .rdata        (rdata),
      .sram_cs      (sram_cs),
      .sram_wr_en   (sram_wr_en),
      .sram_addr    (sram_addr),
      .sram_wr_data (sram_wr_data),
      .sram_rd_data (sram_rd_data)
   );

   // Behavioural single-port SRAM with registered read data.
   always @(posedge clk) begin
      if (sram_cs) begin
         if (sram_wr_en) sram_mem[sram_addr] <= sram_wr_data;
         else            sram_rd_data <= sram_mem[sram_addr];
      end
   end

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Response monitor: every rvalid must match the oldest expected read.
   always @(negedge clk) begin
      if (rvalid0 || rvalid1) begin
         chk("rv_both", {7'd0, rvalid0 & rvalid1}, 8'd0);
         if (q.size() == 0) begin
            chk("rv_spurious", 8'd1, 8'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rv_id", {7'd0, rvalid1}, {7'd0, e.id});
            chk("rv_data", {4'd0, rdata}, {4'd0, e.data});
         end
      end
   end

   task automatic drive(input logic r0, input logic w0, input logic [A-1:0] a0, input logic [W-1:0] d0,
                        input logic r1, input logic w1, input logic [A-1:0] a1, input logic [W-1:0] d1);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
   endtask

   // Check one cycle's grant and pin values; account the expected access.
   task automatic cycle(input logic eg0, input logic eg1);
      logic         e_we;
      logic [A-1:0] e_a;
      logic [W-1:0] e_d;
      @(negedge clk); #1;
      e_we = 1'b0; e_a = '0; e_d = '0;
      if (eg1)      begin e_we = we1; e_a = addr1; e_d = wdata1; end
      else if (eg0) begin e_we = we0; e_a = addr0; e_d = wdata0; end
      chk("gnt0", {7'd0, gnt0}, {7'd0, eg0});
      chk("gnt1", {7'd0, gnt1}, {7'd0, eg1});
      chk("cs", {7'd0, sram_cs}, {7'd0, eg0 | eg1});
      chk("wr_en", {7'd0, sram_wr_en}, {7'd0, e_we});
      chk("addr", {6'd0, sram_addr}, {6'd0, e_a});
      chk("wdata", {4'd0, sram_wr_data}, {4'd0, e_d});
      if (eg0 || eg1) begin
         if (e_we) ref_mem[e_a] = e_d;
         else      q.push_back('{id: eg1, data: ref_mem[e_a]});
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1, 0, 2'd1, 4'h0, 1, 0, 2'd2, 4'h0);
      repeat (2) begin
         @(negedge clk); #1;
         chk("rst_gnt", {6'd0, gnt1, gnt0}, 8'd0);
         chk("rst_cs", {7'd0, sram_cs}, 8'd0);
         chk("rst_pins", {1'b0, sram_wr_en, sram_addr, sram_wr_data}, 8'd0);
         chk("rst_rv", {6'd0, rvalid1, rvalid0}, 8'd0);
         @(posedge clk); #1;
      end
      drive(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0);
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         ref_mem[i]  = '0;
         sram_mem[i] = '0;
      end
      sram_rd_data = '0;
      drive(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      do_reset();

      // Write then read the same address.
      drive(1, 1, 2'd2, 4'hA, 0, 0, 2'd0, 4'h0); cycle(1, 0);
      drive(1, 0, 2'd2, 4'h0, 0, 0, 2'd0, 4'h0); cycle(1, 0);
      drive(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0); cycle(0, 0);

      // Continuous read contention alternates starting with master 0.
      do_reset();
      drive(1, 0, 2'd2, 4'h0, 1, 0, 2'd0, 4'h0);
      for (int i = 0; i < 4; i++) cycle(i % 2 == 0, i % 2 == 1);
      drive(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0); cycle(0, 0);

      // Fill from master 1, read back in reverse from master 0.
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 2'd0, 4'h0, 1, 1, 2'(i), 4'(5 + i)); cycle(0, 1);
      end
      for (int i = 3; i >= 0; i--) begin
         drive(1, 0, 2'(i), 4'h0, 0, 0, 2'd0, 4'h0); cycle(1, 0);
      end
      drive(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0); cycle(0, 0);

      // Write from 0 and read from 1 contend on one address.
      do_reset();
      drive(1, 1, 2'd1, 4'hC, 1, 0, 2'd1, 4'h0); cycle(1, 0);
      drive(0, 0, 2'd0, 4'h0, 1, 0, 2'd1, 4'h0); cycle(0, 1);
      drive(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0); cycle(0, 0);

      // Read to master 1 killed by reset at the capturing edge.
      drive(0, 0, 2'd0, 4'h0, 1, 0, 2'd3, 4'h0);
      @(negedge clk); #1;
      chk("kill_gnt1", {7'd0, gnt1}, 8'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      drive(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0);
      @(negedge clk); #1;
      chk("kill_rv1", {7'd0, rvalid1}, 8'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(1, 0, 2'd0, 4'h0, 1, 0, 2'd1, 4'h0); cycle(1, 0);
      drive(0, 0, 2'd0, 4'h0, 1, 0, 2'd1, 4'h0); cycle(0, 1);

      // Idle.
      drive(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0);
      for (int i = 0; i < 5; i++) cycle(0, 0);

      chk("q_drained", 8'(q.size()), 8'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
